tlb_inv_walker: RTL and testbench

- Multi-cycle sequencer that executes one INVTLB instruction by walking every TLB entry in turn.
- For each entry it reads the entry, evaluates the op-specific match rule, and clears the E bit of each matching entry.
- Sits between the commit/control logic and the TLB. The commit side supplies the decoded INVTLB request; the walker drives the TLB read and invalidate ports.
- Holds `inv_stallreq` high until the walk completes, so the commit stage holds the pipeline.

---
 rtl/tlb_inv_walker.sv | 169 ++++++++++++++++
 tb/tb_tlb_inv_walker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_inv_walker.sv
// tlb_inv_walker: executes one INVTLB by walking every TLB entry.
// It reads each entry in turn, applies the op-specific match rule to the
// data returned one cycle later, and clears the E bit of every matching
// entry. The pipeline is held for the whole walk.
`timescale 1ns/1ps
module tlb_inv_walker #(
    parameter int TLBNUM = 32,
    parameter int IDX_W  = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inv_req_valid,
    input  logic [4:0]       inv_req_op,
    input  logic [9:0]       inv_req_asid,
    input  logic [18:0]      inv_req_vppn,
    output logic             inv_req_ready,
    input  logic             abort,
    output logic             tlb_rd_en,
    output logic [IDX_W-1:0] tlb_rd_idx,
    input  logic             tlb_rd_e,
    input  logic             tlb_rd_g,
    input  logic [9:0]       tlb_rd_asid,
    input  logic [18:0]      tlb_rd_vppn,
    input  logic [5:0]       tlb_rd_ps,
    output logic             tlb_inv_we,
    output logic [IDX_W-1:0] tlb_inv_idx,
    output logic             inv_stallreq,
    output logic             inv_done,
    output logic             ine_excp,
    output logic [IDX_W:0]   inv_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WALK  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    // Op-specific match rule; E is checked separately by the caller.
    function automatic logic entry_match(input logic [4:0] op,
                                         input logic       g,
                                         input logic       asid_eq,
                                         input logic       vppn_eq);
        logic m;
        case (op)
            5'd0, 5'd1: m = 1'b1;
            5'd2:       m = g;
            5'd3:       m = ~g;
            5'd4:       m = ~g & asid_eq;
            5'd5:       m = ~g & asid_eq & vppn_eq;
            5'd6:       m = (g | asid_eq) & vppn_eq;
            default:    m = 1'b0;
        endcase
        return m;
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [IDX_W-1:0] cnt_r;
    logic [IDX_W:0]   hit_cnt_r;
    logic [IDX_W:0]   inv_cnt_r;
    logic [4:0]       op_r;
    logic [9:0]       asid_r;
    logic [18:0]      vppn_r;

    logic             idle_s;
    logic             op_legal_s;
    logic             accept_s;
    logic             eval_s;
    logic             asid_eq_s;
    logic             vppn_eq_s;
    logic             hit_s;
    logic [IDX_W-1:0] eval_idx_s;

    assign idle_s     = (state_r == S_IDLE);
    assign op_legal_s = (inv_req_op <= 5'd6);
    assign accept_s   = inv_req_valid & idle_s & ~abort & op_legal_s;
    // Read data refers to the index issued last cycle; in DRAIN cnt_r has
    // wrapped to 0, so cnt_r-1 is the last index as required.
    assign eval_idx_s = cnt_r - ONE_IDX;
    assign eval_s     = (((state_r == S_WALK) && (cnt_r != '0)) ||
                         (state_r == S_DRAIN)) && !abort;
    assign asid_eq_s  = (tlb_rd_asid == asid_r);
    // Huge (2 MB) pages ignore the low nine VPPN bits.
    assign vppn_eq_s  = (tlb_rd_ps == 6'd21) ? (tlb_rd_vppn[18:9] == vppn_r[18:9])
                                             : (tlb_rd_vppn == vppn_r);
    assign hit_s      = eval_s & tlb_rd_e &
                        entry_match(op_r, tlb_rd_g, asid_eq_s, vppn_eq_s);

    // Next-state selection for the walk sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = S_WALK;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WALK: begin
                if (abort) begin
                    state_nxt_s = S_IDLE;
                end else if (cnt_r == LAST_IDX) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s = S_WALK;
                end
            end
            S_DRAIN: state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Sequencer state, counters and latched request operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= '0;
            hit_cnt_r <= '0;
            inv_cnt_r <= '0;
            op_r      <= 5'd0;
            asid_r    <= 10'd0;
            vppn_r    <= 19'd0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                cnt_r     <= '0;
                hit_cnt_r <= '0;
                op_r      <= inv_req_op;
                asid_r    <= inv_req_asid;
                vppn_r    <= inv_req_vppn;
            end else begin
                if ((state_r == S_WALK) && !abort) begin
                    cnt_r <= cnt_r + ONE_IDX;
                end
                if (hit_s) begin
                    hit_cnt_r <= hit_cnt_r + {{IDX_W{1'b0}}, 1'b1};
                end
                if ((state_r == S_DRAIN) && !abort) begin
                    inv_cnt_r <= hit_cnt_r + {{IDX_W{1'b0}}, hit_s};
                end
            end
        end
    end

    // Output decode; handshake outputs are forced low while reset is held.
    always_comb begin
        inv_req_ready = rst & idle_s & ~abort;
        ine_excp      = rst & idle_s & ~abort & inv_req_valid & ~op_legal_s;
        inv_stallreq  = rst & (~idle_s | (inv_req_valid & op_legal_s));
        tlb_rd_en     = (state_r == S_WALK) & ~abort;
        if (state_r == S_WALK) begin
            tlb_rd_idx = cnt_r;
        end else begin
            tlb_rd_idx = '0;
        end
        tlb_inv_we    = hit_s;
        if (hit_s) begin
            tlb_inv_idx = eval_idx_s;
        end else begin
            tlb_inv_idx = '0;
        end
        inv_done      = (state_r == S_DRAIN) & ~abort;
        inv_cnt       = inv_cnt_r;
    end

endmodule

// File: tb/tb_tlb_inv_walker.sv
// Directed testbench for tlb_inv_walker with a small behavioural TLB.
`timescale 1ns/1ps
module tb_tlb_inv_walker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inv_req_valid = 1'b0;
    logic [4:0]  inv_req_op = 5'd0;
    logic [9:0]  inv_req_asid = 10'd0;
    logic [18:0] inv_req_vppn = 19'd0;
    logic        inv_req_ready;
    logic        abort = 1'b0;
    logic        tlb_rd_en;
    logic [4:0]  tlb_rd_idx;
    logic        tlb_rd_e = 1'b0;
    logic        tlb_rd_g = 1'b0;
    logic [9:0]  tlb_rd_asid = 10'd0;
    logic [18:0] tlb_rd_vppn = 19'd0;
    logic [5:0]  tlb_rd_ps = 6'd0;
    logic        tlb_inv_we;
    logic [4:0]  tlb_inv_idx;
    logic        inv_stallreq;
    logic        inv_done;
    logic        ine_excp;
    logic [5:0]  inv_cnt;

    tlb_inv_walker #(.TLBNUM(32)) dut (
        .clk(clk), .rst(rst),
        .inv_req_valid(inv_req_valid), .inv_req_op(inv_req_op),
        .inv_req_asid(inv_req_asid), .inv_req_vppn(inv_req_vppn),
        .inv_req_ready(inv_req_ready), .abort(abort),
        .tlb_rd_en(tlb_rd_en), .tlb_rd_idx(tlb_rd_idx),
        .tlb_rd_e(tlb_rd_e), .tlb_rd_g(tlb_rd_g), .tlb_rd_asid(tlb_rd_asid),
        .tlb_rd_vppn(tlb_rd_vppn), .tlb_rd_ps(tlb_rd_ps),
        .tlb_inv_we(tlb_inv_we), .tlb_inv_idx(tlb_inv_idx),
        .inv_stallreq(inv_stallreq), .inv_done(inv_done),
        .ine_excp(ine_excp), .inv_cnt(inv_cnt)
    );

    always #5 clk = ~clk;

    // TLB contents driven only by the stimulus process.
    logic        m_e    [32];
    logic        m_g    [32];
    logic [9:0]  m_asid [32];
    logic [18:0] m_vppn [32];
    logic [5:0]  m_ps   [32];

    // TLB read port: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (tlb_rd_en) begin
            tlb_rd_e    <= m_e[tlb_rd_idx];
            tlb_rd_g    <= m_g[tlb_rd_idx];
            tlb_rd_asid <= m_asid[tlb_rd_idx];
            tlb_rd_vppn <= m_vppn[tlb_rd_idx];
            tlb_rd_ps   <= m_ps[tlb_rd_idx];
        end
    end

    int cyc = 0;
    int wr_q[$];
    int wr_cyc_q[$];
    int rd_n = 0;
    int done_n = 0;
    int done_cyc = -1;
    int stall_n = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Monitor: counts cycles and logs DUT activity mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (tlb_inv_we) begin
            wr_q.push_back(int'(tlb_inv_idx));
            wr_cyc_q.push_back(cyc);
        end
        if (tlb_rd_en)    rd_n = rd_n + 1;
        if (inv_stallreq) stall_n = stall_n + 1;
        if (inv_done) begin
            done_n   = done_n + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wr_q.delete();
        wr_cyc_q.delete();
        rd_n = 0; done_n = 0; done_cyc = -1; stall_n = 0;
    endtask

    task automatic clear_tlb();
        for (int i = 0; i < 32; i++) begin
            m_e[i] = 1'b0; m_g[i] = 1'b0; m_asid[i] = 10'd0;
            m_vppn[i] = 19'd0; m_ps[i] = 6'd12;
        end
    endtask

    task automatic set_entry(input int i, input logic g, input logic [9:0] asid,
                             input logic [18:0] vppn, input logic [5:0] ps);
        m_e[i] = 1'b1; m_g[i] = g; m_asid[i] = asid; m_vppn[i] = vppn; m_ps[i] = ps;
    endtask

    // Issues a legal request; returns its accept cycle number.
    task automatic start_walk(input logic [4:0] op, input logic [9:0] asid,
                              input logic [18:0] vppn, output int t0);
        @(posedge clk); #1;
        clear_logs();
        inv_req_valid = 1'b1; inv_req_op = op;
        inv_req_asid = asid; inv_req_vppn = vppn;
        t0 = cyc + 1;
        @(negedge clk);
        check("accept_ready", inv_req_ready, 1);
        check("accept_stall", inv_stallreq, 1);
        @(posedge clk); #1;
        inv_req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_n == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done_n == 0) check("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input int exp_q[$]);
        check({tag, "_nwr"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check({tag, "_idx"}, wr_q[i], exp_q[i]);
    endtask

    initial begin
        int t0;
        int exp_q[$];

        clear_tlb();
        #12;
        check("rst_ready", inv_req_ready, 0);
        check("rst_stall", inv_stallreq, 0);
        check("rst_rd_en", tlb_rd_en, 0);
        check("rst_we", tlb_inv_we, 0);
        check("rst_cnt", inv_cnt, 0);
        @(posedge clk); #1 rst = 1'b1;

        // Full walk, every entry valid, op 0.
        for (int i = 0; i < 32; i++) set_entry(i, 1'b0, 10'd0, 19'd0, 6'd12);
        start_walk(5'd0, 10'd0, 19'd0, t0);
        wait_done();
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(i);
        check_writes("full", exp_q);
        if (wr_cyc_q.size() > 0) check("full_first_wr_cyc", wr_cyc_q[0] - t0, 2);
        check("full_done_cyc", done_cyc - t0, 33);
        check("full_done_n", done_n, 1);
        check("full_rd_n", rd_n, 32);
        check("full_stall_n", stall_n, 34);
        check("full_cnt", inv_cnt, 32);
        check("full_stall_after", inv_stallreq, 0);

        // op 4 ASID match, G=1 entry must survive.
        clear_tlb();
        set_entry(3, 1'b1, 10'd5, 19'd0, 6'd12);
        set_entry(7, 1'b0, 10'd5, 19'd0, 6'd12);
        start_walk(5'd4, 10'd5, 19'd0, t0);
        wait_done();
        exp_q = '{7};
        check_writes("op4", exp_q);
        if (wr_cyc_q.size() > 0) check("op4_wr_cyc", wr_cyc_q[0] - t0, 9);
        check("op4_cnt", inv_cnt, 1);

        // op 5 on a 2 MB page ignores VPPN bits [8:0].
        clear_tlb();
        set_entry(9, 1'b0, 10'd2, 19'h12A00, 6'd21);
        start_walk(5'd5, 10'd2, 19'h12A1F, t0);
        wait_done();
        exp_q = '{9};
        check_writes("op5_huge", exp_q);
        check("op5_huge_cnt", inv_cnt, 1);

        // Same request against a 4 KB page: full compare, no hit.
        m_ps[9] = 6'd12;
        start_walk(5'd5, 10'd2, 19'h12A1F, t0);
        wait_done();
        exp_q.delete();
        check_writes("op5_small", exp_q);
        check("op5_small_cnt", inv_cnt, 0);

        // op 3 and op 6 on a shared table.
        clear_tlb();
        set_entry(4, 1'b1, 10'd9, 19'h00100, 6'd12);
        set_entry(5, 1'b0, 10'd3, 19'h00100, 6'd12);
        set_entry(6, 1'b0, 10'd7, 19'h00100, 6'd12);
        set_entry(8, 1'b0, 10'd3, 19'h00200, 6'd12);
        start_walk(5'd3, 10'd0, 19'd0, t0);
        wait_done();
        exp_q = '{5, 6, 8};
        check_writes("op3", exp_q);
        check("op3_cnt", inv_cnt, 3);
        start_walk(5'd6, 10'd3, 19'h00100, t0);
        wait_done();
        exp_q = '{4, 5};
        check_writes("op6", exp_q);
        check("op6_cnt", inv_cnt, 2);

        // Illegal op raises INE and starts nothing.
        @(posedge clk); #1;
        clear_logs();
        inv_req_valid = 1'b1; inv_req_op = 5'd7;
        @(negedge clk);
        check("ine_pulse", ine_excp, 1);
        check("ine_ready", inv_req_ready, 1);
        @(posedge clk); #1 inv_req_valid = 1'b0;
        @(negedge clk);
        check("ine_clear", ine_excp, 0);
        check("ine_stall_after", inv_stallreq, 0);
        repeat (3) @(negedge clk);
        check("ine_rd_n", rd_n, 0);
        check("ine_nwr", wr_q.size(), 0);
        check("ine_cnt", inv_cnt, 2);

        // Abort at cycle 10 of a full walk.
        for (int i = 0; i < 32; i++) set_entry(i, 1'b0, 10'd0, 19'd0, 6'd12);
        start_walk(5'd0, 10'd0, 19'd0, t0);
        repeat (9) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        check("abort_we", tlb_inv_we, 0);
        check("abort_done", inv_done, 0);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_idle_stall", inv_stallreq, 0);
        check("abort_idle_ready", inv_req_ready, 1);
        repeat (5) @(negedge clk);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_writes("abort", exp_q);
        check("abort_done_n", done_n, 0);
        check("abort_cnt", inv_cnt, 2);

        // Reset at cycle 5 of a walk, then a fresh full walk.
        start_walk(5'd0, 10'd0, 19'd0, t0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_stall", inv_stallreq, 0);
        check("mid_rst_rd_en", tlb_rd_en, 0);
        check("mid_rst_we", tlb_inv_we, 0);
        check("mid_rst_cnt", inv_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        exp_q = '{0, 1, 2};
        check_writes("mid_rst", exp_q);
        start_walk(5'd0, 10'd0, 19'd0, t0);
        wait_done();
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(i);
        check_writes("post_rst", exp_q);
        check("post_rst_cnt", inv_cnt, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
